// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: register map,
// CTRL field layout, MODE encodings and FSM state encoding.
package timer_dev_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // Field order mirrors CTRL bits [3:0], so the struct reads back as-is.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

  function automatic tmr_ctrl_t ctrl_from_word(input logic [3:0] w);
    tmr_ctrl_t c;
    c.en   = w[CTRL_EN_BIT];
    c.mode = w[CTRL_MODE_LSB +: 2];
    c.im   = w[CTRL_IM_BIT];
    return c;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Countdown timer on the data-memory store bus: CTRL/PRESET/COUNT registers,
// a four-state load/count/interrupt FSM and a combinational read mux.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  tmr_state_e           state_q, state_d;
  tmr_ctrl_t            ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 irq_flag_q, irq_flag_d;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case leaves it unassigned (no latch).
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > COUNT_W'(1)) begin
          count_d = count_q - COUNT_W'(1);
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) irq_flag_d = 1'b0;
        else                            ctrl_d.en  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Bus stores are applied last so they override same-cycle FSM updates.
    if (WE) begin
      case (addr)
        TMR_CTRL: begin
          ctrl_d     = ctrl_from_word(WD[3:0]);
          irq_flag_d = 1'b0;
        end
        TMR_PRESET: begin
          preset_d   = WD[COUNT_W-1:0];
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    RD = '0;
    case (addr)
      TMR_CTRL:   RD = {28'b0, ctrl_q};
      TMR_PRESET: RD = 32'(preset_q);
      TMR_COUNT:  RD = 32'(count_q);
      default:    RD = '0;
    endcase
  end

  assign IRQ = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized
// trials checked against a closed-form timing model of the timer.
module tb_timer_dev;
  import timer_dev_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        IRQ;

  int n_tests = 0;
  int n_fail  = 0;

  timer_dev #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .WE    (WE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    WD   = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    WD   = '0;
  endtask

  task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, RD, exp);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // Timing model; k = rising edges since the CTRL store that set EN, starting from count 0.
  function automatic int eff_n(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int model_count(input int n, input bit reload, input int k);
    int j;
    if (k < 2) return 0;
    j = k - 2;
    if (reload) j = j % (eff_n(n) + 3);
    if (j >= eff_n(n)) return 0;
    return n - j;
  endfunction

  function automatic bit model_flag(input int n, input bit reload, input int k);
    if (k < 2) return 1'b0;
    if (reload) return ((k - 2) % (eff_n(n) + 3)) == eff_n(n);
    return (k - 2) >= eff_n(n);
  endfunction

  function automatic bit model_en(input int n, input bit reload, input int k);
    if (reload) return 1'b1;
    return k < eff_n(n) + 3;
  endfunction

  initial begin
    int          n;
    logic [1:0]  mode;
    logic        im;
    bit          reload;
    int          exp_os [11];

    exp_os = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0, 0};

    do_reset(2);

    // Reset after arbitrary activity.
    store(TMR_PRESET, 32'd7);
    store(TMR_CTRL, 32'hB);
    repeat (5) tick();
    do_reset(2);
    check_rd("rst_ctrl", TMR_CTRL, 32'h0);
    check_rd("rst_preset", TMR_PRESET, 32'h0);
    check_rd("rst_count", TMR_COUNT, 32'h0);
    check_rd("rst_rsvd", TMR_RSVD, 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    // From IDLE, an enable takes LOAD then CNT before the preset appears.
    store(TMR_PRESET, 32'd2);
    store(TMR_CTRL, 32'h1);
    tick();
    check_rd("rst_idle_k1", TMR_COUNT, 32'd0);
    tick();
    check_rd("rst_idle_k2", TMR_COUNT, 32'd2);

    // One-shot, PRESET=5, CTRL=0x9.
    do_reset(1);
    store(TMR_PRESET, 32'd5);
    store(TMR_CTRL, 32'h9);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      check_rd("os_count", TMR_COUNT, 32'(exp_os[k]));
      check("os_irq", 32'(IRQ), (k >= 7) ? 32'd1 : 32'd0);
      check_rd("os_ctrl", TMR_CTRL, (k >= 8) ? 32'h8 : 32'h9);
    end
    store(TMR_PRESET, 32'd5);
    check("os_irq_clear", 32'(IRQ), 32'd0);

    // Auto-reload, PRESET=3, CTRL=0xB: pulses at k = 5, 11, 17.
    do_reset(1);
    store(TMR_PRESET, 32'd3);
    store(TMR_CTRL, 32'hB);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      check("ar_irq", 32'(IRQ), (k == 5 || k == 11 || k == 17) ? 32'd1 : 32'd0);
      check_rd("ar_ctrl", TMR_CTRL, 32'hB);
    end

    // Masked expiry with PRESET=0, then a CTRL store clears the hidden flag.
    do_reset(1);
    store(TMR_PRESET, 32'd0);
    store(TMR_CTRL, 32'h1);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      check_rd("mask_count", TMR_COUNT, 32'd0);
      check("mask_irq", 32'(IRQ), 32'd0);
    end
    check_rd("mask_en_cleared", TMR_CTRL, 32'h0);
    store(TMR_CTRL, 32'h9);
    check("mask_flag_cleared", 32'(IRQ), 32'd0);

    // CTRL store collides with the INT-state EN clear.
    do_reset(1);
    store(TMR_PRESET, 32'd3);
    store(TMR_CTRL, 32'h1);
    repeat (5) tick();
    check_rd("col_int_count", TMR_COUNT, 32'd0);
    store(TMR_CTRL, 32'h1);
    check_rd("col_ctrl", TMR_CTRL, 32'h1);

    // PRESET store during CNT affects only the next LOAD.
    do_reset(1);
    store(TMR_PRESET, 32'd6);
    store(TMR_CTRL, 32'h1);
    repeat (3) tick();
    check_rd("pcnt_k3", TMR_COUNT, 32'd5);
    store(TMR_PRESET, 32'd2);
    check_rd("pcnt_k4", TMR_COUNT, 32'd4);
    tick();
    check_rd("pcnt_k5", TMR_COUNT, 32'd3);
    check_rd("pcnt_preset", TMR_PRESET, 32'd2);
    repeat (5) tick();
    check_rd("pcnt_done_ctrl", TMR_CTRL, 32'h0);
    store(TMR_CTRL, 32'h1);
    repeat (2) tick();
    check_rd("pcnt_reload", TMR_COUNT, 32'd2);

    // Ignored stores to COUNT and the reserved offset.
    do_reset(1);
    store(TMR_PRESET, 32'd9);
    store(TMR_COUNT, 32'hFFFF_FFFF);
    store(TMR_RSVD, 32'hFFFF_FFFF);
    check_rd("ign_count", TMR_COUNT, 32'd0);
    check_rd("ign_rsvd", TMR_RSVD, 32'd0);
    check_rd("ign_preset", TMR_PRESET, 32'd9);
    check_rd("ign_ctrl", TMR_CTRL, 32'h0);

    // Reset in the middle of a count.
    store(TMR_PRESET, 32'd8);
    store(TMR_CTRL, 32'h9);
    repeat (6) tick();
    check_rd("mid_count4", TMR_COUNT, 32'd4);
    reset = 1'b0;
    tick();
    check_rd("mid_ctrl", TMR_CTRL, 32'h0);
    check_rd("mid_preset", TMR_PRESET, 32'h0);
    check_rd("mid_count", TMR_COUNT, 32'h0);
    check("mid_irq", 32'(IRQ), 32'd0);
    reset = 1'b1;

    // Randomized trials against the timing model.
    for (int t = 0; t < 12; t++) begin
      n      = int'($urandom_range(0, 9));
      mode   = 2'($urandom_range(0, 3));
      im     = 1'($urandom_range(0, 1));
      reload = (mode == MODE_RELOAD);
      do_reset(1);
      store(TMR_PRESET, 32'(n));
      store(TMR_CTRL, {28'b0, im, mode, 1'b1});
      for (int k = 0; k <= 3 * (eff_n(n) + 3) + 2; k++) begin
        if (k > 0) tick();
        check_rd("rnd_count", TMR_COUNT, 32'(model_count(n, reload, k)));
        check("rnd_irq", 32'(IRQ), 32'(im & model_flag(n, reload, k)));
        check_rd("rnd_ctrl", TMR_CTRL, {28'b0, im, mode, model_en(n, reload, k)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds to CPU data-bus loads and stores and raises an interrupt request when its count expires. It sits behind the data-memory address decode, on the same store-enable / write-data / address path that the pipeline uses for DM. It is the device end of that bus: the CPU initiates, and this block responds.

## Interface
- `COUNT_W`, default 32: counter and preset width, 1..32; reads zero-extend to 32 bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `addr`, input, 2: word offset (bus address bits [3:2]). 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `WE`, input, 1: store enable for the addressed register this cycle.
- `WD`, input, 32: store data.
- `RD`, output, 32: combinational read of the addressed register.
- `IRQ`, output, 1: interrupt request; `IRQ = CTRL.IM & irq_flag`.

## Operation
- **CTRL register:**
  - bit0 EN: enable.
  - bits[2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - bit3 IM: interrupt mask, 1 = IRQ allowed.
  - bits[31:4] are read as 0 and ignored on write.
- **PRESET register:** read/write, low `COUNT_W` bits of `WD`.
- **COUNT register:** read-only; stores to offset 2 are ignored.
- **Offset 3:** reads 0; stores are ignored.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: `count <= PRESET`; go to CNT.
  - CNT:
    - If EN==0, go to IDLE and hold count.
    - Else if `count > 1`, decrement count.
    - Else set `count <= 0` and `irq_flag <= 1`, and go to INT.
  - INT, MODE 00: clear EN, go to IDLE, keep `irq_flag`.
  - INT, MODE 01: clear `irq_flag`, go to IDLE. EN stays set, so the block reloads automatically.
- **irq_flag clear:** a store to CTRL or PRESET clears it.
- **Store to CTRL vs. FSM:** a store to CTRL in the same cycle as the INT-state EN clear wins; the stored value is taken.
- **Store to PRESET while counting:** affects the next LOAD only, never the running count.
- **PRESET = 0 or 1:** CNT expires on its first cycle.
- **Reset:** CTRL, PRESET, count and `irq_flag` go to 0 and the FSM goes to IDLE. This applies mid-count or mid-INT.
  - IRQ is 0 out of reset.
  - RD out of reset shows 0 at every offset.

## Timing
- Reads are combinational with zero latency. A read in the cycle after a store returns the new value.
- **Mode 00, PRESET = N ≥ 1, store CTRL.EN=1 at edge e:**
  - e+1: LOAD.
  - e+2: CNT with count = N.
  - e+N+2: count = 0, INT, IRQ rises (if IM).
  - e+N+3: IDLE, EN = 0.
  - IRQ holds high until a CTRL or PRESET store.
- **Mode 01:** IRQ is a one-cycle pulse, high from e+N+2 to e+N+3. The period is N+3 cycles: INT→IDLE→LOAD→CNT.
- **EN cleared by store during CNT:** the FSM is in IDLE on the next edge and count freezes. Setting EN again restarts from LOAD, so the count reloads.
- **No pipeline stall interaction:** the block never back-pressures; every store completes in one cycle.

## Structure
- The shared constants file carries:
  - register offsets `TMR_CTRL`, `TMR_PRESET`, `TMR_COUNT`;
  - CTRL bit positions EN/MODE/IM;
  - MODE encodings;
  - the 2-bit FSM state encodings.
- Single module with no sub-module. The counter and FSM are small enough to stay in one always block with a separate read mux.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles after arbitrary stores → RD=0 at all offsets, IRQ=0, FSM in IDLE.
- **One-shot:** PRESET=5, CTRL=0x9 (EN, mode 00, IM) → COUNT reads 5,4,3,2,1,0. IRQ rises 7 cycles after the CTRL store and stays high. CTRL then reads 0x8. A store of PRESET=5 drops IRQ.
- **Auto-reload:** PRESET=3, CTRL=0xB → IRQ pulses one cycle wide, every 6 cycles, over at least 3 periods. EN stays 1.
- **Mask and boundary:**
  - CTRL=0x1 with PRESET=0 → COUNT goes to 0 and IRQ stays 0.
  - A following CTRL=0x9 store clears the flag.
- **Collision:** store CTRL=0x1 in the same cycle as the INT state → CTRL reads 0x1 afterwards. A PRESET store during CNT leaves the running count unchanged.
- **Mid-count reset and ignored stores:**
  - Store to offsets 2 and 3 → no effect.
  - `reset=0` during CNT with count=4 → all registers read 0 on the next cycle, IRQ=0.
